// File: rtl/csa_resolver_if.sv
// Handshake bundle for csa_resolver: carry-save input pair in, resolved binary word out.
interface csa_resolver_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             in_of;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_of;

  modport master (
    output in_valid, in_sum, in_carry, in_of, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_of
  );

  modport slave (
    input  in_valid, in_sum, in_carry, in_of, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_of
  );
endinterface

// File: rtl/csa_resolver.sv
// Resolves a carry-save sum/carry pair into binary with a CHUNK-bit ripple adder, one slice per clock.
// Optional macro CSA_RESOLVER_SAT_EN: saturate out_result to all ones when out_of is set.
module csa_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  csa_resolver_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("csa_resolver: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sum_q, carry_q, res_q;
  logic [IW-1:0]    idx;
  logic             rc, of_q;
  logic             in_ready_q, out_valid_q, cout_q, oflag_q;
  logic [CHUNK:0]   slice;

  // One CHUNK-bit slice of the carry-propagate add, selected by the running index.
  always_comb begin
    slice = {1'b0, sum_q[idx*CHUNK +: CHUNK]}
          + {1'b0, carry_q[idx*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, rc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sum_q       <= '0;
      carry_q     <= '0;
      res_q       <= '0;
      idx         <= '0;
      rc          <= 1'b0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      oflag_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sum_q      <= bus.in_sum;
            carry_q    <= bus.in_carry;
            of_q       <= bus.in_of;
            idx        <= '0;
            rc         <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= ADD;
          end
        end
        ADD: begin
          res_q[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
          rc  <= slice[CHUNK];
          idx <= idx + 1'b1;
          if (idx == IW'(NCHUNK-1)) begin
            cout_q      <= slice[CHUNK];
            oflag_q     <= of_q | slice[CHUNK];
            out_valid_q <= 1'b1;
            state       <= DONE;
`ifdef CSA_RESOLVER_SAT_EN
            // Overrides the final slice write above when the result overflowed.
            if (of_q | slice[CHUNK]) res_q <= '1;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_of     = oflag_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed plan items plus randomized transactions vs. an arithmetic model.
module tb_csa_resolver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  csa_resolver_if #(.WIDTH(16)) bus ();
  csa_resolver #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {out_of, out_cout, out_result} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] s, input logic [15:0] c, input logic o);
    int unsigned t;
    logic [15:0] r;
    logic        co, ofo;
    t   = int'(s) + int'(c);
    co  = (t >= 65536);
    r   = 16'(t % 65536);
    ofo = o | co;
`ifdef CSA_RESOLVER_SAT_EN
    if (ofo) r = 16'hFFFF;
`endif
    return {ofo, co, r};
  endfunction

  task automatic wait_out(input string tag);
    int lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
  endtask

  task automatic check_out(input string tag, input logic [17:0] e);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_res"}, 32'(bus.out_result), 32'(e[15:0]));
    chk({tag, "_cout"}, 32'(bus.out_cout), 32'(e[16]));
    chk({tag, "_of"}, 32'(bus.out_of), 32'(e[17]));
  endtask

  task automatic run_txn(input logic [15:0] s, input logic [15:0] c, input logic o,
                         input int stall, input string tag);
    logic [17:0] e;
    int w = 0;
    e = model(s, c, o);
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_inrdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_sum = s; bus.in_carry = c; bus.in_of = o; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_out(tag);
    repeat (stall) tick();
    check_out(tag, e);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [17:0] e;
    int tq[$];
    logic [16:0] rq[$];
    int acc;
    bit take;

    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_carry = '0; bus.in_of = 1'b0;
    bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_inrdy", 32'(bus.in_ready), 32'd1);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'(bus.out_result), 32'd0);
    chk("rst_cout", 32'(bus.out_cout), 32'd0);
    chk("rst_of", 32'(bus.out_of), 32'd0);

    run_txn(16'h00FF, 16'h0001, 1'b0, 0, "basic");
    run_txn(16'hFFFF, 16'h0002, 1'b0, 0, "ovf");
    run_txn(16'h1234, 16'h0000, 1'b1, 0, "upof");

    // Backpressure: second pair must wait until the first result is consumed.
    e = model(16'h4321, 16'h0F0F, 1'b0);
    bus.in_sum = 16'h4321; bus.in_carry = 16'h0F0F; bus.in_of = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_sum = 16'h0001; bus.in_carry = 16'h0001;
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("bp_hold", e);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_idle", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_acc", 32'(bus.in_ready), 32'd0);
    wait_out("bp2");
    check_out("bp2", model(16'h0001, 16'h0001, 1'b0));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset during the second ADD cycle aborts the transaction.
    bus.in_sum = 16'hFFFF; bus.in_carry = 16'hFFFF; bus.in_of = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_inrdy", 32'(bus.in_ready), 32'd1);
    chk("mrst_vld", 32'(bus.out_valid), 32'd0);
    chk("mrst_res", 32'(bus.out_result), 32'd0);
    chk("mrst_of", 32'(bus.out_of), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_novld", 32'(bus.out_valid), 32'd0);
    end
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0, "post_rst");

    // Back-to-back with out_ready tied high.
    bus.out_ready = 1'b1;
    bus.in_sum = 16'h0F0F; bus.in_carry = 16'h00F2; bus.in_of = 1'b0; bus.in_valid = 1'b1;
    acc = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      take = bus.in_ready && bus.in_valid;
      tick();
      if (take) begin
        acc++;
        if (acc == 1) begin
          bus.in_sum = 16'hAAAA; bus.in_carry = 16'h5556;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        tq.push_back(cyc);
        rq.push_back({bus.out_cout, bus.out_result});
      end
    end
    bus.out_ready = 1'b0;
    chk("b2b_cnt", 32'(tq.size()), 32'd2);
    if (tq.size() >= 2) begin
      e = model(16'h0F0F, 16'h00F2, 1'b0);
      chk("b2b_r0", 32'(rq[0]), 32'(e[16:0]));
      e = model(16'hAAAA, 16'h5556, 1'b0);
      chk("b2b_r1", 32'(rq[1]), 32'(e[16:0]));
      chk("b2b_gap", 32'(tq[1] - tq[0]), 32'd6);
    end
    tick();

    for (int n = 0; n < 40; n++) begin
      logic [15:0] s, c;
      s = 16'($urandom);
      c = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 7) == 0) c[0] = 1'b1;
      run_txn(s, c, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Converts a carry-save (redundant sum/carry) 16-bit result into a single binary word.
- It is the consuming end of the 3:2 compressor output, giving a final carry-propagate add.
- Sequential: a ripple add over CHUNK-bit slices, one slice per clock, to keep the adder small.
- valid/ready handshake on both sides; single transaction in flight.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits resolved per clock. WIDTH % CHUNK must be 0; otherwise elaboration error.
- NCHUNK (localparam), WIDTH/CHUNK, number of add cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word pair valid.
- in_ready  output  1  block can accept a pair.
- in_sum  input  WIDTH  sum vector from the carry-save stage.
- in_carry  input  WIDTH  carry vector, already shifted left one place; bit 0 is normally 0 but is added if set.
- in_of  input  1  overflow flag from the carry-save stage (carry out of its MSB).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  resolved in_sum + in_carry, modulo 2^WIDTH.
- out_cout  output  1  carry out of the final add.
- out_of  output  1  in_of OR out_cout.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State becomes IDLE.
  - in_ready=1, out_valid=0, out_result=0, out_cout=0, out_of=0.
  - Internal registers (operands, carry, chunk index) are cleared.
  - Reset during ADD or DONE aborts the transaction. No out_valid is produced for it.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - At an edge with in_valid=1: latch in_sum, in_carry and in_of; chunk index=0; running carry=0; go to ADD.
- ADD:
  - in_ready=0.
  - Each edge adds slice i (bits i*CHUNK+CHUNK-1 : i*CHUNK) of sum, carry and the running carry.
  - The CHUNK-bit slice result is written into the result register; the slice carry-out becomes the running carry; the index increments.
  - After slice NCHUNK-1:
    - out_cout = final carry; out_of = in_of_latched | final carry.
    - out_result holds the full sum.
    - Go to DONE, with out_valid=1 visible from that edge.
  - Latency: out_valid rises exactly NCHUNK edges after the accepting edge (4 with defaults).
- DONE:
  - out_valid=1, in_ready=0.
  - out_result, out_cout and out_of stay stable until handshake.
  - At an edge with out_ready=1: out_valid→0 and go to IDLE.
- Throughput: one transaction per NCHUNK+2 edges (6 with defaults) when out_ready is held high.
- While in_ready=0, in_valid is ignored; the source must hold its data.
- out_result, out_cout and out_of are updated only as above; they retain their last value in IDLE.
- Arithmetic is unsigned, with wrap-around modulo 2^WIDTH.

Optional Feature:
- Macro: CSA_RESOLVER_SAT_EN.
- Defined: when the computed out_of=1, out_result is forced to all ones (16'hFFFF) on entry to DONE. out_cout and out_of are unchanged.
- Undefined: out_result is the wrapped sum. No saturation logic is present.

Test Plan:
- Basic add: in_sum=0x00FF, in_carry=0x0001, in_of=0 → out_result=0x0100, out_cout=0, out_of=0; out_valid exactly 4 edges after accept.
- Carry overflow: in_sum=0xFFFF, in_carry=0x0002 → out_result=0x0001 (0xFFFF with SAT_EN), out_cout=1, out_of=1.
- Upstream overflow flag: in_sum=0x1234, in_carry=0x0000, in_of=1 → out_cout=0, out_of=1, out_result=0x1234 (0xFFFF with SAT_EN).
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: output is stable, in_ready=0.
  - A second in_valid with 0x0001/0x0001 is not accepted.
  - Raise out_ready: the first result is consumed; the second pair is accepted next cycle and gives 0x0002.
- Reset mid-operation: assert rst during the 2nd ADD cycle → next cycle in_ready=1, out_valid=0, outputs 0. A following transaction 0x7FFF+0x0001 gives 0x8000, out_of=0.
- Back-to-back: out_ready tied 1, in_valid held with pairs (0x0F0F,0x00F2) then (0xAAAA,0x5556) → results 0x1001 then 0x0000 with out_cout=1, out_valid pulses spaced 6 edges apart.
